serial_hamming_decoder: RTL and testbench
=========================================

SERIAL_HAMMING_DECODER -- requirements
Module: serial_hamming_decoder

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: d_in  input  1  serial codeword bit, sampled only when strobe_in=1.
REQ-004 SHALL have port: strobe_in  input  1  bit-valid qualifier, one bit per cycle with strobe_in high.
REQ-005 SHALL have port: data_out  output  4  decoded nibble {pos7,pos6,pos5,pos3}.
REQ-006 SHALL have port: syndrome  output  3  {c4,c2,c1} of last codeword; 0 means no error.
REQ-007 SHALL have port: valid_out  output  1  one-cycle pulse, data_out/syndrome/err_flag valid.
REQ-008 SHALL have port: err_flag  output  1  syndrome nonzero for last codeword.
REQ-009 SHALL have port: err_count  output  8  saturating count of codewords with nonzero syndrome.

Function
REQ-010 SHALL receive 7-bit Hamming(7,4) codewords MSB first: position 7 first, position 1 last.
REQ-011 SHALL use a 3-bit down-counter bit_pos, 6 on frame start, decremented per accepted bit; bit 0 closes the frame.
REQ-012 SHALL shift accepted bits into a 7-bit register; cycles with strobe_in=0 leave state unchanged (gaps allowed mid-frame).
REQ-013 SHALL implement FSM S_IDLE -> S_RECV on first accepted bit; S_RECV -> S_DONE on 7th accepted bit; S_DONE -> S_IDLE, or S_RECV if strobe_in=1 in S_DONE.
REQ-014 SHALL accept a strobed bit in S_DONE as bit position 7 of the next frame (back-to-back frames, no dead cycle).
REQ-015 SHALL compute c1=p1^p3^p5^p7, c2=p2^p3^p6^p7, c4=p4^p5^p6^p7 over received positions.
REQ-016 SHALL invert the bit at position syndrome when syndrome is nonzero, before extracting data_out.
REQ-017 SHALL assert valid_out exactly in the cycle after the clock edge sampling the 7th bit (latency 1 cycle); deassert otherwise.
REQ-018 SHALL hold data_out, syndrome, err_flag stable between valid_out pulses.
REQ-019 SHALL increment err_count by 1 on each valid_out with err_flag=1; saturate at 8'hFF.
REQ-020 SHALL not detect double errors; they are miscorrected as single errors.

Reset
REQ-021 SHALL on rst=1 set FSM to S_IDLE, bit_pos to 6, shift register to 0, and data_out, syndrome, valid_out, err_flag, err_count to 0.
REQ-022 SHALL discard a partial frame on rst mid-frame; the next strobed bit after rst is position 7.
REQ-023 SHALL give rst priority over strobe_in in the same cycle.

Configuration
REQ-024 SHALL provide macro SERIAL_HAMMING_DECODER_CORRECT_EN.
REQ-025 SHALL, with the macro defined, correct single-bit errors per REQ-016.
REQ-026 SHALL, without the macro, pass raw received data bits to data_out uncorrected; syndrome, err_flag and err_count still operate.

Structure
REQ-027 SHALL place CW_LEN=7, DATA_W=4, syndrome typedef (3-bit), FSM state enum, and position constants in package hamming_pkg.
REQ-028 SHALL place syndrome computation and correction in combinational sub-module hamming74_syndrome (in: 7-bit codeword; out: syndrome, corrected codeword).

Verification
REQ-029 SHALL cover: bits 1,0,1,0,1,0,1 strobed on consecutive cycles -> valid_out 1 cycle later, data_out=4'b1011, syndrome=0, err_flag=0.
REQ-030 SHALL cover: bits 1,0,0,0,1,0,1 (pos5 flipped) -> data_out=4'b1011, syndrome=3'd5, err_flag=1, err_count=1; without macro data_out=4'b1001.
REQ-031 SHALL cover: 1111111 then 0000000 back-to-back, no idle cycle -> two valid_out pulses 7 cycles apart, data_out=4'b1111 then 4'b0000.
REQ-032 SHALL cover: 1010101 with strobe_in low for 3 cycles between each bit -> identical result to REQ-029, single valid_out.
REQ-033 SHALL cover: 3 bits, then rst for 1 cycle, then 1010101 -> only one valid_out, data_out=4'b1011, err_count=0.
REQ-034 SHALL cover: 260 frames each with one injected error -> err_count holds 8'hFF.

Source files
------------

// File: rtl/hamming_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hamming_pkg
//  Brief    : Shared constants and types for the serial Hamming(7,4) decoder.
//             Codeword bit index i holds Hamming position i+1.
//  Revision : 1.0  initial release
// ============================================================================
package hamming_pkg;

   localparam int CW_LEN = 7;
   localparam int DATA_W = 4;
   localparam int SYN_W  = 3;

   // Hamming positions that carry data bits
   localparam int POS_D3 = 3;
   localparam int POS_D5 = 5;
   localparam int POS_D6 = 6;
   localparam int POS_D7 = 7;

   // bit_pos value loaded at the start of every frame
   localparam logic [2:0] BIT_POS_START = 3'd6;

   typedef logic [SYN_W-1:0] syndrome_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RECV = 2'd1,
      S_DONE = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/hamming74_syndrome.sv
`default_nettype none
// ============================================================================
//  Module   : hamming74_syndrome
//  Brief    : Combinational Hamming(7,4) syndrome generator and single-bit
//             corrector. With CORRECT_EN=0 the codeword passes through raw.
//  Revision : 1.0  initial release
// ============================================================================
module hamming74_syndrome
   import hamming_pkg::*;
#(
   parameter bit CORRECT_EN = 1'b1
) (
   input  logic [CW_LEN-1:0] i_codeword,
   output syndrome_t         o_syndrome,
   output logic [CW_LEN-1:0] o_corrected
);

   logic w_c1;
   logic w_c2;
   logic w_c4;
   logic [CW_LEN-1:0] w_flip;

   // Parity checks; index i is Hamming position i+1
   always_comb begin
      w_c1 = i_codeword[0] ^ i_codeword[2] ^ i_codeword[4] ^ i_codeword[6];
      w_c2 = i_codeword[1] ^ i_codeword[2] ^ i_codeword[5] ^ i_codeword[6];
      w_c4 = i_codeword[3] ^ i_codeword[4] ^ i_codeword[5] ^ i_codeword[6];
   end

   assign o_syndrome = {w_c4, w_c2, w_c1};

   // One-hot mask selecting the position named by a nonzero syndrome
   always_comb begin
      w_flip = '0;
      for (int i = 0; i < CW_LEN; i++) begin
         w_flip[i] = CORRECT_EN && (o_syndrome == syndrome_t'(i + 1));
      end
   end

   assign o_corrected = i_codeword ^ w_flip;

endmodule
`default_nettype wire

// File: rtl/serial_hamming_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_hamming_decoder
//  Brief    : Serial Hamming(7,4) receiver. Bits arrive MSB (position 7)
//             first, qualified by strobe_in; result pulses valid_out one
//             cycle after the 7th bit. Back-to-back frames supported.
//  Config   : define SERIAL_HAMMING_DECODER_CORRECT_EN to enable single-bit
//             correction; otherwise raw data bits are output.
//  Revision : 1.0  initial release
// ============================================================================
module serial_hamming_decoder
   import hamming_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              d_in,
   input  logic              strobe_in,
   output logic [DATA_W-1:0] data_out,
   output syndrome_t         syndrome,
   output logic              valid_out,
   output logic              err_flag,
   output logic [7:0]        err_count
);

`ifdef SERIAL_HAMMING_DECODER_CORRECT_EN
   localparam bit c_CORRECT_EN = 1'b1;
`else
   localparam bit c_CORRECT_EN = 1'b0;
`endif

   state_t              r_state;
   state_t              w_next_state;
   logic [2:0]          r_bit_pos;
   logic [CW_LEN-1:0]   r_shift;
   logic [DATA_W-1:0]   r_data;
   syndrome_t           r_syn;
   logic                r_valid;
   logic                r_err;
   logic [7:0]          r_err_cnt;

   logic                w_frame_end;
   logic [CW_LEN-1:0]   w_shift_next;
   syndrome_t           w_syn;
   logic [CW_LEN-1:0]   w_data_cw;

   // Codeword as it will look once the current bit is shifted in
   assign w_shift_next = {r_shift[CW_LEN-2:0], d_in};

   hamming74_syndrome #(
      .CORRECT_EN (c_CORRECT_EN)
   ) u_syndrome (
      .i_codeword  (w_shift_next),
      .o_syndrome  (w_syn),
      .o_corrected (w_data_cw)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next_state;
   end

   // FSM next-state logic; a strobe in S_DONE starts the next frame directly
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (strobe_in) w_next_state = S_RECV;
         S_RECV:  if (w_frame_end) w_next_state = S_DONE;
         S_DONE:  w_next_state = strobe_in ? S_RECV : S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // FSM outputs: the 7th accepted bit closes the frame
   always_comb begin
      w_frame_end = strobe_in && (r_state == S_RECV) && (r_bit_pos == 3'd0);
   end

   // Bit counter, shift register and result registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_bit_pos <= BIT_POS_START;
         r_shift   <= '0;
         r_data    <= '0;
         r_syn     <= '0;
         r_valid   <= 1'b0;
         r_err     <= 1'b0;
         r_err_cnt <= '0;
      end else begin
         r_valid <= w_frame_end;
         if (strobe_in) begin
            r_shift   <= w_shift_next;
            r_bit_pos <= (r_bit_pos == 3'd0) ? BIT_POS_START : r_bit_pos - 3'd1;
         end
         if (w_frame_end) begin
            r_data <= {w_data_cw[POS_D7-1], w_data_cw[POS_D6-1],
                       w_data_cw[POS_D5-1], w_data_cw[POS_D3-1]};
            r_syn  <= w_syn;
            r_err  <= (w_syn != '0);
            if ((w_syn != '0) && (r_err_cnt != 8'hFF)) begin
               r_err_cnt <= r_err_cnt + 8'd1;
            end
         end
      end
   end

   assign data_out  = r_data;
   assign syndrome  = r_syn;
   assign valid_out = r_valid;
   assign err_flag  = r_err;
   assign err_count = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_serial_hamming_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_hamming_decoder
//  Brief    : Directed, table-driven bench for serial_hamming_decoder.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_hamming_decoder;

   logic       clk;
   logic       rst;
   logic       d_in;
   logic       strobe_in;
   logic [3:0] data_out;
   logic [2:0] syndrome;
   logic       valid_out;
   logic       err_flag;
   logic [7:0] err_count;

   int n_tests = 0;
   int n_fail  = 0;
   int n_pulse = 0;
   int frames_done = 0;
   int cyc = 0;
   int last_cyc = 0;
   int exp_cnt = 0;

   serial_hamming_decoder dut (
      .clk       (clk),
      .rst       (rst),
      .d_in      (d_in),
      .strobe_in (strobe_in),
      .data_out  (data_out),
      .syndrome  (syndrome),
      .valid_out (valid_out),
      .err_flag  (err_flag),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (valid_out === 1'b1) n_pulse++;
   end

   typedef struct {
      logic [6:0] cw;      // bit 6 = position 7 (sent first)
      logic [3:0] d_corr;  // expected data with correction enabled
      logic [3:0] d_raw;   // expected data without correction
      logic [2:0] syn;
   } vec_t;

   vec_t vecs[8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] pick(input logic [3:0] corr, input logic [3:0] raw);
`ifdef SERIAL_HAMMING_DECODER_CORRECT_EN
      return corr;
`else
      return raw;
`endif
   endfunction

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         strobe_in = 1'b0;
         d_in      = 1'b0;
      end
   endtask

   // Send one frame, position 7 first, with 'gap' idle cycles after each bit;
   // the result is checked one cycle after the 7th bit is sampled.
   task automatic send_frame(input logic [6:0] cw, input logic [3:0] ed,
                             input logic [2:0] es, input int gap, input string tag);
      for (int i = 6; i >= 0; i--) begin
         @(negedge clk);
         strobe_in = 1'b1;
         d_in      = cw[i];
         if (i == 0) begin
            @(posedge clk);
            #1;
            if (es != 3'd0 && exp_cnt != 255) exp_cnt++;
            chk({tag, ".pulses_before"}, n_pulse, frames_done);
            chk({tag, ".valid_out"}, valid_out, 1'b1);
            chk({tag, ".data_out"}, data_out, ed);
            chk({tag, ".syndrome"}, syndrome, es);
            chk({tag, ".err_flag"}, err_flag, (es != 3'd0));
            chk({tag, ".err_count"}, err_count, exp_cnt);
            frames_done++;
            last_cyc = cyc;
         end
         if (gap > 0) idle(gap);
      end
   endtask

   initial begin
      int t_first;
      vecs[0] = '{7'b1010101, 4'b1011, 4'b1011, 3'd0};
      vecs[1] = '{7'b1000101, 4'b1011, 4'b1001, 3'd5};
      vecs[2] = '{7'b1111111, 4'b1111, 4'b1111, 3'd0};
      vecs[3] = '{7'b0000000, 4'b0000, 4'b0000, 3'd0};
      vecs[4] = '{7'b1010100, 4'b1011, 4'b1011, 3'd1};
      vecs[5] = '{7'b0010101, 4'b1011, 4'b0011, 3'd7};
      vecs[6] = '{7'b1111011, 4'b1111, 4'b1110, 3'd3};
      vecs[7] = '{7'b1010110, 4'b1010, 4'b1011, 3'd3};  // double error, miscorrected

      rst = 1'b1; strobe_in = 1'b0; d_in = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset.data_out", data_out, 4'd0);
      chk("reset.syndrome", syndrome, 3'd0);
      chk("reset.valid_out", valid_out, 1'b0);
      chk("reset.err_flag", err_flag, 1'b0);
      chk("reset.err_count", err_count, 8'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table-driven frames, short idle between
      for (int v = 0; v < 8; v++) begin
         send_frame(vecs[v].cw, pick(vecs[v].d_corr, vecs[v].d_raw), vecs[v].syn, 0,
                    $sformatf("vec%0d", v));
         idle(2);
      end

      // Back-to-back frames: pulses 7 cycles apart
      send_frame(7'b1111111, 4'b1111, 3'd0, 0, "b2b_a");
      t_first = last_cyc;
      send_frame(7'b0000000, 4'b0000, 3'd0, 0, "b2b_b");
      chk("b2b.spacing", last_cyc - t_first, 7);
      idle(2);

      // Gapped bits and output hold between pulses
      send_frame(7'b1010101, 4'b1011, 3'd0, 3, "gap");
      idle(3);
      #1;
      chk("hold.valid_out", valid_out, 1'b0);
      chk("hold.data_out", data_out, 4'b1011);

      // Partial frame, then reset with strobe high (reset wins)
      @(negedge clk); strobe_in = 1'b1; d_in = 1'b0;
      @(negedge clk); d_in = 1'b1;
      @(negedge clk); d_in = 1'b1;
      @(negedge clk); rst = 1'b1; d_in = 1'b1;
      @(negedge clk); rst = 1'b0; strobe_in = 1'b0; d_in = 1'b0;
      chk("midrst.err_count", err_count, 8'd0);
      chk("midrst.valid_out", valid_out, 1'b0);
      exp_cnt = 0;
      send_frame(7'b1010101, 4'b1011, 3'd0, 0, "after_rst");
      idle(2);

      // Saturation: 260 single-error frames
      for (int f = 0; f < 260; f++) begin
         send_frame(7'b1000101, pick(4'b1011, 4'b1001), 3'd5, 0, "sat");
      end
      idle(3);
      #1;
      chk("sat.final_count", err_count, 8'hFF);
      chk("final.pulses", n_pulse, frames_done);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
